// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Word-addressed data-memory responder for a simple CPU. It accepts one load
//   or store at a time, waits a fixed number of cycles, and then raises a
//   one-cycle ready strobe. At that strobe it returns load data, or it reports
//   an error for a misaligned or out-of-range address.
//
// Parameters:
//   ADDR_W - RAM word-index width (2^ADDR_W words of 32 bits)
//   WAIT   - wait cycles inserted before each response (0..15)
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - synchronous active-low reset
//   req   - request valid, sampled only in IDLE
//   we    - 1 = store, 0 = load
//   addr  - 32-bit byte address
//   wdata - store data
//   rdata - load data, meaningful while ready = 1
//   ready - one-cycle response strobe
//   err   - error flag, meaningful while ready = 1
//   busy  - high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_ST = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    localparam logic [3:0] WAIT_LD = 4'(WAIT);
    localparam int         DEPTH   = 1 << ADDR_W;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [31:0]       cap_addr;
    logic              cap_we;
    logic [31:0]       cap_wdata;

    logic [31:0]       mem [DEPTH];

    logic [31:0]       src_addr;
    logic              src_we;
    logic [31:0]       src_wdata;
    logic              src_err;
    logic [ADDR_W-1:0] src_idx;
    logic              commit;

    // With WAIT = 0, RESP is entered on the acceptance edge itself, so the
    // commit has to use the live inputs rather than the not-yet-captured copy.
    always_comb begin
        src_addr  = cap_addr;
        src_we    = cap_we;
        src_wdata = cap_wdata;
        if (state == IDLE) begin
            src_addr  = addr;
            src_we    = we;
            src_wdata = wdata;
        end
        src_err = (src_addr[1:0] != 2'b00) ||
                  ((src_addr >> (ADDR_W + 2)) != 32'd0);
        src_idx = src_addr[ADDR_W+1:2];
        commit  = ((state == IDLE) && req && (WAIT == 0)) ||
                  ((state == WAIT_ST) && (cnt == 4'd1));
    end

    assign busy = (state != IDLE);

    // Control FSM plus response registers. The commit happens on the edge that
    // enters RESP; rdata and err then hold until the next commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 32'd0;
            cap_we    <= 1'b0;
            cap_wdata <= 32'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_addr  <= addr;
                        cap_we    <= we;
                        cap_wdata <= wdata;
                        cnt       <= WAIT_LD;
                        state     <= (WAIT == 0) ? RESP : WAIT_ST;
                    end
                end
                WAIT_ST: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (commit) begin
                ready <= 1'b1;
                err   <= src_err;
                if (src_err || src_we) begin
                    rdata <= 32'd0;
                end else begin
                    rdata <= mem[src_idx];
                end
            end
        end
    end

    // RAM contents are deliberately not reset; the rst gate only keeps a
    // reset edge from committing a pending store.
    always_ff @(posedge clk) begin
        if (rst && commit && !src_err && src_we) begin
            mem[src_idx] <= src_wdata;
        end
    end

endmodule
